// File: rtl/svn_disp_arb_if.sv
// Display-share bus between requesters and the seven-segment arbiter.
// master = requester side, slave = arbiter side.
interface svn_disp_arb_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic [15:0]         disp_data;
  logic                disp_busy;
  logic [1:0]          owner;

  modport master (
    output req, req_data,
    input  ack, disp_data, disp_busy, owner
  );

  modport slave (
    input  req, req_data,
    output ack, disp_data, disp_busy, owner
  );
endinterface

// File: rtl/svn_disp_arb.sv
// Round-robin owner of the 4-digit seven-segment driver, fixed dwell per grant.
// SVN_DISP_ARB_PRIO_EN: requester 0 wins every arbitration it is eligible for.
module svn_disp_arb #(
  parameter int N_REQ     = 3,
  parameter int DWELL_CYC = 16000000,
  parameter int CNT_W     = 24
) (
  input  logic         clk_16M,
  input  logic         rst_n,
  svn_disp_arb_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [15:0]      data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [3:0] elig;
  logic [3:0] req_w;
  logic [2:0] idx;
  logic [1:0] win;
  logic [1:0] nxt;
  logic       found;

  assign req_w = 4'(bus.req);
  assign nxt   = (owner_q == 2'(N_REQ - 1)) ? 2'd0 : owner_q + 2'd1;

  // The requester just acked is skipped so a held req cannot re-grab at once.
  always_comb begin
    elig  = 4'(bus.req & ~ack_q);
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
`ifdef SVN_DISP_ARB_PRIO_EN
    if (elig[0]) begin
      found = 1'b1;
      win   = 2'd0;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + 3'(k);
      if (idx >= 3'(N_REQ))
        idx = idx - 3'(N_REQ);
      if (!found && elig[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    data_d  = data_q;
    busy_d  = busy_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          owner_d = win;
          data_d  = bus.req_data[16*int'(win) +: 16];
          busy_d  = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        data_d  = bus.req_data[16*int'(owner_q) +: 16];
        timer_d = timer_q + 1'b1;
        if (!req_w[owner_q]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ptr_d   = nxt;
        end else if (timer_q == CNT_W'(DWELL_CYC - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ptr_d   = nxt;
          ack_d   = N_REQ'(4'b0001 << owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_16M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.disp_data = data_q;
  assign bus.disp_busy = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_svn_disp_arb.sv
// Bench for svn_disp_arb: directed scenarios plus random traffic
// against a grant/dwell model of the display ownership rules.
module tb_svn_disp_arb;
  localparam int N = 3;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [15:0] data [N];

  always #5 clk = ~clk;

  svn_disp_arb_if #(.N_REQ(N)) bus();

  assign bus.req      = req;
  assign bus.req_data = {data[2], data[1], data[0]};

  svn_disp_arb #(
    .N_REQ(N), .DWELL_CYC(D), .CNT_W(24)
  ) dut (
    .clk_16M(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model: who holds the display, for how many cycles, whose turn is next
  bit           m_act;
  int           m_own, m_held, m_ptr;
  logic [15:0]  m_data;
  logic [N-1:0] m_ack;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] el);
`ifdef SVN_DISP_ARB_PRIO_EN
    if (el[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (el[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_own = 0; m_held = 0; m_ptr = 0;
    m_data = '0; m_ack = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] prev;
    int w;
    prev  = m_ack;
    m_ack = '0;
    if (m_act) begin
      m_data = data[m_own];
      if (!req[m_own]) begin
        m_act = 0;
        m_ptr = (m_own + 1) % N;
      end else begin
        m_held++;
        if (m_held == D) begin
          m_act = 0;
          m_ack[m_own] = 1'b1;
          m_ptr = (m_own + 1) % N;
        end
      end
    end else begin
      w = pick(req & ~prev);
      if (w >= 0) begin
        m_own = w; m_data = data[w]; m_act = 1; m_held = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("disp_data", 32'(bus.disp_data), 32'(m_data));
    chk("disp_busy", 32'(bus.disp_busy), 32'(m_act));
    chk("owner", 32'(bus.owner), 32'(m_own));
    chk("ack", 32'(bus.ack), 32'(m_ack));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req = r;
    #1;
    model_reset();
    chk("rst_data", 32'(bus.disp_data), 32'h0);
    chk("rst_busy", 32'(bus.disp_busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq [4];
  int grants [$];
  int acks;
  logic pb;

  initial begin
    data[0] = 16'h5A01; data[1] = 16'h1234; data[2] = 16'h0C0C;
    model_reset();

    // reset and first grant
    do_reset(3'b111);
    cycle();
    chk("s1_owner", 32'(bus.owner), 32'h0);
    chk("s1_data", 32'(bus.disp_data), 32'h5A01);
    chk("s1_busy", 32'(bus.disp_busy), 32'h1);

    // single request, ack exactly D edges after grant
    req = '0;
    cycle();
    cycle();
    req = 3'b010;
    data[1] = 16'h1234;
    cycle();
    chk("s2_data", 32'(bus.disp_data), 32'h1234);
    for (int j = 1; j <= D; j++) begin
      cycle();
      chk("s2_ack", 32'(bus.ack), (j == D) ? 32'h2 : 32'h0);
    end
    req = '0;
    cycle();
    chk("s2_idle", 32'(bus.disp_busy), 32'h0);
    cycle();
    chk("s2_idle2", 32'(bus.disp_busy), 32'h0);

    // contention: grant order and ack count
    data[0] = 16'hAAAA; data[1] = 16'hBBBB; data[2] = 16'hCCCC;
`ifdef SVN_DISP_ARB_PRIO_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 1, 2, 0};
`endif
    do_reset(3'b111);
    pb = 1'b0;
    acks = 0;
    grants.delete();
    for (int c = 0; c < 22; c++) begin
      cycle();
      if (bus.disp_busy && !pb) grants.push_back(int'(bus.owner));
      if (bus.ack != '0) acks++;
      pb = bus.disp_busy;
    end
    chk("s3_ngrant", 32'(grants.size() >= 4), 32'h1);
    for (int g = 0; g < 4; g++)
      if (g < grants.size())
        chk("s3_order", 32'(grants[g]), 32'(exp_seq[g]));
    chk("s3_acks", 32'(acks), 32'h4);

    // abort of owner 1 at timer 1, then requester 2
    do_reset(3'b110);
    cycle();
    chk("s4_owner", 32'(bus.owner), 32'h1);
    cycle();
    req = 3'b100;
    cycle();
    chk("s4_busy", 32'(bus.disp_busy), 32'h0);
    chk("s4_ack", 32'(bus.ack), 32'h0);
    cycle();
    chk("s4_next", 32'(bus.owner), 32'h2);
    chk("s4_nbusy", 32'(bus.disp_busy), 32'h1);

    // live data update while holding
    data[0] = 16'h0001;
    do_reset(3'b001);
    cycle();
    data[0] = 16'h0002;
    cycle();
    chk("s5_live", 32'(bus.disp_data), 32'h0002);
    for (int j = 2; j <= D; j++) begin
      cycle();
      chk("s5_ack", 32'(bus.ack), (j == D) ? 32'h1 : 32'h0);
    end
    req = '0;
    cycle();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset(N'($urandom));
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = ($urandom % 4 == 0);
        else if (m_act && m_own == i) begin
          if ($urandom % 24 == 0) req[i] = 1'b0;
        end else if ($urandom % 16 == 0) req[i] = 1'b0;
        if ($urandom % 8 == 0) data[i] = 16'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/svn_disp_arb.md
Name: svn_disp_arb

Overview:
- Round-robin arbiter that shares the single 4-digit seven-segment display driver between up to 4 requesters.
- The granted requester owns the display for a fixed dwell time, then receives a one-cycle ack.
- Drives the 16-bit hex word into the display driver's data input. Runs on the 16 MHz board clock.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- DWELL_CYC, 16000000, ownership period in clk_16M cycles (1 s). Must be >= 2.
- CNT_W, 24, dwell timer width. Must hold DWELL_CYC-1.

Ports:
- clk_16M  input  1  16 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  level request per requester. Held until ack or abandoned.
- req_data  input  16*N_REQ  packed display words; requester i uses bits [16i+15:16i].
- ack  output  N_REQ  one-cycle pulse to the owner when its dwell completes.
- disp_data  output  16  word to the display driver (nibble 0 = rightmost digit).
- disp_busy  output  1  high while a requester owns the display.
- owner  output  2  index of the current or last owner.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=IDLE; disp_data=16'h0000, ack=0, disp_busy=0, owner=0.
  - Round-robin pointer ptr=0; dwell timer=0.
- States: IDLE, HOLD. All outputs are registered.
- IDLE:
  - Eligible set = req, with the requester acked in this same cycle masked out.
  - If the eligible set is non-empty, grant the first asserted index searching ptr, ptr+1, … modulo N_REQ.
  - On that edge: owner<=winner, disp_data<=req_data[winner], disp_busy<=1, timer<=0, state<=HOLD.
  - Grant latency: req seen high at edge k → disp_data valid in the cycle after edge k.
  - If the eligible set is empty, remain in IDLE. disp_data holds its last value (no blanking); disp_busy=0.
- HOLD:
  - disp_data tracks req_data[owner] every edge (live update, one-cycle latency).
  - Timer increments each edge.
  - On the edge where timer==DWELL_CYC-1: state<=IDLE, ack[owner]<=1 for exactly one cycle, disp_busy<=0, ptr<=(owner+1) mod N_REQ.
  - HOLD therefore lasts exactly DWELL_CYC cycles, followed by at least one IDLE cycle.
- Abort: if req[owner] is low while in HOLD, on that edge state<=IDLE, no ack, disp_busy<=0, ptr<=(owner+1) mod N_REQ. Abort takes precedence over dwell completion on the same edge.
- Requesters must deassert req the cycle after ack. If req is still high afterwards, the requester is eligible again at the following arbitration.
- Reset mid-HOLD: immediate return to reset values; no ack is emitted.
- req bits and req_data slices at indices >= N_REQ do not exist. owner never exceeds N_REQ-1.
- ack is one-hot or zero at all times.

Optional Feature:
- Macro: SVN_DISP_ARB_PRIO_EN.
- Defined: requester 0 is fixed-high-priority at every arbitration point. If req[0] is eligible it wins regardless of ptr; otherwise round-robin applies among the rest. There is no preemption of a running HOLD.
- Undefined: pure round-robin as described above.

Test Plan:
All scenarios use DWELL_CYC=4, N_REQ=3.
1. Reset: rst_n=0 with req=3'b111 → disp_data=16'h0000, ack=0, disp_busy=0, owner=0. Release rst_n → one edge later owner=0, disp_data=req_data[0], disp_busy=1.
2. Single request: req=3'b010, data1=16'h1234 → disp_data=16'h1234 one edge later. ack=3'b010 for one cycle exactly 4 edges after the grant edge. Requester drops req → disp_busy stays 0.
3. Contention: req=3'b111 held continuously with distinct data (16'hAAAA/16'hBBBB/16'hCCCC) → owner sequence 0,1,2,0. Each owner holds for 4 cycles with a 1-cycle IDLE gap. Each ack pulse is observed once per grant.
4. Abort: owner=1; drop req[1] when timer=1 → IDLE next edge, no ack[1], then grant to 2 (ptr=2).
5. Live update: during HOLD of owner 0, change data0 from 16'h0001 to 16'h0002 → disp_data=16'h0002 one edge later, with no change to timer or ack timing.
6. With SVN_DISP_ARB_PRIO_EN and req=3'b111, after owner 1's ack → next grant is 0, not 2. Without the macro → next grant is 2.
